// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-stream command decoder driving a register file.
//   0xAA <addr> <data>  -> register write (one-cycle WrEn)
//   0xBB <addr>         -> register read (one-cycle RdEn), the read byte is
//                          returned to the transmitter via TX_D_VLD/TX_RDY
// Unknown command bytes, and bytes arriving while a read is in flight,
// produce a one-cycle ERR pulse.
// Optional build macro REG_CMD_TIMEOUT_EN adds an 8-bit inactivity counter
// that abandons a stalled frame; without it the frame states wait forever.
module reg_cmd_ctrl #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             TX_RDY,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic             WrEn,
    output logic             RdEn,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             ERR
);

    localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]   wrdata_q, wrdata_d;
    logic               wren_q, wren_d;
    logic               rden_q, rden_d;
    logic [WIDTH-1:0]   txdata_q, txdata_d;
    logic               txvld_q, txvld_d;
    logic               err_q, err_d;

`ifdef REG_CMD_TIMEOUT_EN
    logic [7:0]         tmo_q, tmo_d;
    logic               wait_state;
    logic               tmo_hit;

    // Timeout only applies while a frame is waiting for its next input;
    // a byte or read response arriving in the expiry cycle takes priority.
    assign wait_state = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                        (state_q == RD_ADDR) || (state_q == RD_WAIT);
    assign tmo_hit    = wait_state && (tmo_q == 8'hFF) && !RX_D_VLD &&
                        !((state_q == RD_WAIT) && RdData_VLD);
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txdata_d = txdata_q;
        txvld_d  = txvld_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wrdata_d = RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR-1:0];
                    rden_d  = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                if (RdData_VLD) begin
                    txdata_d = RdData;
                    txvld_d  = 1'b1;
                    state_d  = TX_SEND;
                end
            end
            TX_SEND: begin
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                if (TX_RDY) begin
                    txvld_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                txvld_d = 1'b0;
                state_d = IDLE;
            end
        endcase

`ifdef REG_CMD_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
`endif
    end

`ifdef REG_CMD_TIMEOUT_EN
    // Inactivity counter: restarts on every state change and every received
    // byte, saturates at 255 so it cannot wrap while idle.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_d != state_q) || RX_D_VLD) begin
            tmo_d = '0;
        end else if (tmo_q != 8'hFF) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    // Timeout counter register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txdata_q <= '0;
            txvld_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txdata_q <= txdata_d;
            txvld_q  <= txvld_d;
            err_q    <= err_d;
        end
    end

    // Write and read strobes are mutually exclusive by construction.
    assert property (@(posedge CLK) !(wren_q && rden_q));

    assign Address   = addr_q;
    assign WrData    = wrdata_q;
    assign WrEn      = wren_q;
    assign RdEn      = rden_q;
    assign TX_P_DATA = txdata_q;
    assign TX_D_VLD  = txvld_q;
    assign ERR       = err_q;

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/byte width.
REQ-002 SHALL have parameter ADDR, default 4, register address width.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port RX_P_DATA  input  WIDTH  received byte, valid when RX_D_VLD high.
REQ-006 SHALL have port RX_D_VLD  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port RdData  input  WIDTH  read data from register file.
REQ-008 SHALL have port RdData_VLD  input  1  read data valid from register file.
REQ-009 SHALL have port TX_RDY  input  1  transmitter accepts byte when high with TX_D_VLD.
REQ-010 SHALL have port Address  output  ADDR  register file address.
REQ-011 SHALL have port WrData  output  WIDTH  register file write data.
REQ-012 SHALL have port WrEn  output  1  one-cycle write strobe.
REQ-013 SHALL have port RdEn  output  1  one-cycle read strobe.
REQ-014 SHALL have port TX_P_DATA  output  WIDTH  byte to transmitter.
REQ-015 SHALL have port TX_D_VLD  output  1  transmit request, valid/ready handshake with TX_RDY.
REQ-016 SHALL have port ERR  output  1  one-cycle error pulse.

Function
REQ-017 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; all outputs registered.
REQ-018 IDLE: RX byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> stay IDLE, pulse ERR next cycle.
REQ-019 WR_ADDR: on RX_D_VLD latch RX_P_DATA[ADDR-1:0] into Address (upper bits ignored) -> WR_DATA.
REQ-020 WR_DATA: on RX_D_VLD latch byte into WrData, assert WrEn for exactly the following cycle -> IDLE.
REQ-021 RD_ADDR: on RX_D_VLD latch Address, assert RdEn for exactly the following cycle -> RD_WAIT.
REQ-022 RD_WAIT: on RdData_VLD capture RdData into TX_P_DATA, assert TX_D_VLD next cycle -> TX_SEND.
REQ-023 TX_SEND: hold TX_D_VLD and TX_P_DATA stable until cycle with TX_RDY=1; deassert TX_D_VLD the following cycle -> IDLE.
REQ-024 RX_D_VLD in RD_WAIT or TX_SEND: byte discarded, ERR pulsed, state unchanged.
REQ-025 WrEn and RdEn SHALL never be high in the same cycle; neither outside the cycles of REQ-020/021.
REQ-026 Address and WrData SHALL hold last latched value between commands.
REQ-027 RdData_VLD outside RD_WAIT SHALL be ignored.
REQ-028 Back-to-back: 0xAA accepted in the cycle WrEn is asserted (state IDLE) SHALL start a new frame.

Reset
REQ-029 RST high at a clock edge SHALL force IDLE and zero Address, WrData, WrEn, RdEn, TX_P_DATA, TX_D_VLD, ERR, timeout counter.
REQ-030 RST mid-frame (any state, incl. TX_SEND with TX_D_VLD high) SHALL abandon the frame without issuing WrEn/RdEn.

Configuration
REQ-031 Macro REG_CMD_TIMEOUT_EN defined: 8-bit counter clears on state entry and on each RX_D_VLD; in WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT reaching 255 -> IDLE, ERR pulse, no strobe issued.
REQ-032 Macro undefined: no counter; those states wait indefinitely.

Verification
REQ-033 RX 0xAA,0x05,0x3C -> WrEn=1 one cycle after 0x3C strobe, Address=5, WrData=0x3C; ERR never high.
REQ-034 RX 0xBB,0x12, RdData=0x7E with RdData_VLD 1 cycle after RdEn, TX_RDY=0 for 3 cycles -> RdEn one cycle, Address=2, TX_D_VLD high 4+ cycles with TX_P_DATA=0x7E, drops after TX_RDY.
REQ-035 RX 0x55 in IDLE -> ERR one cycle, no WrEn/RdEn; then 0xAA,0x01,0xFF -> normal write.
REQ-036 RX 0xBB,0x03, extra byte 0x99 during RD_WAIT -> ERR pulse, read completes with original data.
REQ-037 RST asserted in WR_DATA after 0xAA,0x04 -> all outputs 0, no WrEn; next frame works.
REQ-038 REG_CMD_TIMEOUT_EN: RX 0xAA then idle 255 cycles -> ERR pulse, IDLE; undefined: remains WR_ADDR.
